// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: groups the fetch stage's IMEM handshake, ID/exception redirects and IF bundle.
// The master modport is the fetch stage; IF_AddrErr exists only when IF_ADDR_ERR_EN is defined.
interface if_fetch_stage_if #(
   parameter int unsigned IMEM_AW = 32
);
   logic               ID_Stall;
   logic               ID_IsBranch;
   logic               ID_BranchTaken;
   logic [IMEM_AW-1:0] ID_BranchTarget;
   logic               ID_CancelBDS;
   logic               EXC_Valid;
   logic [IMEM_AW-1:0] EXC_Vector;
   logic               IMEM_Req;
   logic [IMEM_AW-1:0] IMEM_Addr;
   logic               IMEM_Ready;
   logic [31:0]        IMEM_RData;
   logic [31:0]        IF_Instruction;
   logic [IMEM_AW-1:0] IF_PC;
   logic [IMEM_AW-1:0] PCAdd4;
   logic               IF_IsBDS;
   logic               IF_Stall;
   logic               IF_Flush;
`ifdef IF_ADDR_ERR_EN
   logic               IF_AddrErr;
`endif

   modport master (
      input  ID_Stall, ID_IsBranch, ID_BranchTaken, ID_BranchTarget, ID_CancelBDS,
      input  EXC_Valid, EXC_Vector, IMEM_Ready, IMEM_RData,
`ifdef IF_ADDR_ERR_EN
      output IF_AddrErr,
`endif
      output IMEM_Req, IMEM_Addr, IF_Instruction, IF_PC, PCAdd4, IF_IsBDS, IF_Stall, IF_Flush
   );

   modport slave (
      output ID_Stall, ID_IsBranch, ID_BranchTaken, ID_BranchTarget, ID_CancelBDS,
      output EXC_Valid, EXC_Vector, IMEM_Ready, IMEM_RData,
`ifdef IF_ADDR_ERR_EN
      input  IF_AddrErr,
`endif
      input  IMEM_Req, IMEM_Addr, IF_Instruction, IF_PC, PCAdd4, IF_IsBDS, IF_Stall, IF_Flush
   );
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: owns the fetch PC, drives the IMEM request/ready handshake and the IF/ID bundle.
// Define IF_ADDR_ERR_EN to report misaligned PCs on IF_AddrErr instead of masking IMEM_Addr[1:0].
module if_fetch_stage #(
   parameter int unsigned        IMEM_AW      = 32,
   parameter logic [IMEM_AW-1:0] RESET_VECTOR = 32'hBFC0_0000
) (
   input logic              CLK,
   input logic              RST_N,
   if_fetch_stage_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_HOLD    = 2'd2,
      ST_DISCARD = 2'd3
   } state_e;

`ifdef IF_ADDR_ERR_EN
   localparam logic [IMEM_AW-1:0] ADDR_MASK = {IMEM_AW{1'b1}};
`else
   localparam logic [IMEM_AW-1:0] ADDR_MASK = ~IMEM_AW'(2'b11);
`endif

   state_e             state_q, state_d;
   logic [IMEM_AW-1:0] pc_q, pc_d;
   logic [IMEM_AW-1:0] pend_target_q, pend_target_d;
   logic [IMEM_AW-1:0] stale_addr_q, stale_addr_d;
   logic [31:0]        hold_q, hold_d;
   logic               bds_flag_q, bds_flag_d;
   logic               cancel_flag_q, cancel_flag_d;
   logic               pend_valid_q, pend_valid_d;

   logic               misalign_s, valid_s, exc_s, id_go_s, accept_s, flush_s;
   logic               bds_now_s, taken_now_s, cancel_now_s, req_s;
   logic [31:0]        instr_s;
   logic [IMEM_AW-1:0] imem_addr_s, pc_plus4_s;

`ifdef IF_ADDR_ERR_EN
   assign misalign_s = (state_q == ST_FETCH) && (pc_q[1:0] != 2'b00);
`else
   assign misalign_s = 1'b0;
`endif

   // IDLE is reset-only, so a redirect there is ignored and the flush stays low.
   assign exc_s        = bus.EXC_Valid && (state_q != ST_IDLE);
   assign valid_s      = ((state_q == ST_FETCH) && (bus.IMEM_Ready || misalign_s)) || (state_q == ST_HOLD);
   assign id_go_s      = !bus.ID_Stall && !exc_s;
   assign accept_s     = valid_s && id_go_s;
   assign bds_now_s    = bus.ID_IsBranch && id_go_s;
   assign taken_now_s  = bus.ID_BranchTaken && id_go_s;
   assign cancel_now_s = bus.ID_CancelBDS && id_go_s;
   assign flush_s      = exc_s || (valid_s && (cancel_flag_q || cancel_now_s));
   assign pc_plus4_s   = pc_q + IMEM_AW'(32'd4);
   assign imem_addr_s  = ((state_q == ST_DISCARD) ? stale_addr_q : pc_q) & ADDR_MASK;

   // State register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: state_d = ST_FETCH;
         ST_FETCH: begin
            if (exc_s) begin
               state_d = valid_s ? ST_FETCH : ST_DISCARD;
            end else if (valid_s && bus.ID_Stall && !misalign_s) begin
               state_d = ST_HOLD;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_HOLD: begin
            if (exc_s || !bus.ID_Stall) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_DISCARD: begin
            if (bus.IMEM_Ready) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_DISCARD;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bundle and handshake outputs; the instruction path is combinational from IMEM_RData.
   always_comb begin
      req_s   = 1'b0;
      instr_s = 32'h0000_0000;
      case (state_q)
         ST_FETCH: begin
            req_s   = !misalign_s;
            instr_s = bus.IMEM_RData;
         end
         ST_HOLD: begin
            req_s   = 1'b0;
            instr_s = hold_q;
         end
         ST_DISCARD: begin
            req_s   = 1'b1;
            instr_s = 32'h0000_0000;
         end
         default: begin
            req_s   = 1'b0;
            instr_s = 32'h0000_0000;
         end
      endcase
      if (valid_s && !flush_s && !misalign_s) begin
         bus.IF_Instruction = instr_s;
      end else begin
         bus.IF_Instruction = 32'h0000_0000;
      end
      bus.IMEM_Req  = req_s;
      bus.IMEM_Addr = imem_addr_s;
      bus.IF_PC     = pc_q;
      bus.PCAdd4    = pc_plus4_s;
      bus.IF_Stall  = !valid_s;
      bus.IF_Flush  = flush_s;
      bus.IF_IsBDS  = valid_s && (bds_flag_q || bds_now_s);
`ifdef IF_ADDR_ERR_EN
      bus.IF_AddrErr = misalign_s && !exc_s;
`endif
   end

   // PC, delay-slot bookkeeping and HOLD capture; a branch resolved before its
   // delay slot is accepted parks its target in pend_target until that accept.
   always_comb begin
      pc_d          = pc_q;
      pend_target_d = pend_target_q;
      pend_valid_d  = pend_valid_q;
      stale_addr_d  = stale_addr_q;
      bds_flag_d    = bds_flag_q;
      cancel_flag_d = cancel_flag_q;
      if (exc_s) begin
         pc_d          = bus.EXC_Vector;
         bds_flag_d    = 1'b0;
         cancel_flag_d = 1'b0;
         pend_valid_d  = 1'b0;
         if ((state_q == ST_FETCH) && !valid_s) begin
            stale_addr_d = imem_addr_s;
         end else begin
            stale_addr_d = stale_addr_q;
         end
      end else if (accept_s) begin
         bds_flag_d    = 1'b0;
         cancel_flag_d = 1'b0;
         pend_valid_d  = 1'b0;
         if (pend_valid_q) begin
            pc_d = pend_target_q;
         end else if (taken_now_s) begin
            pc_d = bus.ID_BranchTarget;
         end else begin
            pc_d = pc_plus4_s;
         end
      end else begin
         bds_flag_d    = bds_flag_q || bds_now_s;
         cancel_flag_d = cancel_flag_q || cancel_now_s;
         if (taken_now_s) begin
            pend_valid_d  = 1'b1;
            pend_target_d = bus.ID_BranchTarget;
         end else begin
            pend_valid_d  = pend_valid_q;
            pend_target_d = pend_target_q;
         end
      end
      if ((state_q == ST_FETCH) && bus.IMEM_Ready && bus.ID_Stall && !exc_s && !misalign_s) begin
         hold_d = bus.IMEM_RData;
      end else begin
         hold_d = hold_q;
      end
   end

   // Datapath registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pc_q          <= RESET_VECTOR;
         pend_target_q <= '0;
         pend_valid_q  <= 1'b0;
         stale_addr_q  <= '0;
         hold_q        <= 32'h0000_0000;
         bds_flag_q    <= 1'b0;
         cancel_flag_q <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         pend_target_q <= pend_target_d;
         pend_valid_q  <= pend_valid_d;
         stale_addr_q  <= stale_addr_d;
         hold_q        <= hold_d;
         bds_flag_q    <= bds_flag_d;
         cancel_flag_q <= cancel_flag_d;
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: table-driven check of if_fetch_stage with a per-cycle expectation queue,
// plus hand-written reset and mid-DISCARD reset sequences.
module tb_if_fetch_stage;

   logic CLK = 1'b0;
   logic RST_N;

   if_fetch_stage_if bus_if ();

   if_fetch_stage dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus_if)
   );

   always #5 CLK = ~CLK;

   // in_f  = {stall, ready, isbranch, taken, cancel, exc}
   // exp_f = {req, if_stall, flush, isbds, instruction shown}
   typedef struct packed {
      logic [5:0]  in_f;
      logic [31:0] target;
      logic [31:0] vect;
      logic [4:0]  exp_f;
      logic [31:0] e_addr;
      logic [31:0] e_pc;
   } vec_t;

   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic        stall;
      logic        flush;
      logic        bds;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pcadd4;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0F0F;
   endfunction

   function automatic vec_t mk(input logic [5:0] in_f, input logic [31:0] tgt, input logic [31:0] vc,
                               input logic [4:0] exp_f, input logic [31:0] ea, input logic [31:0] ep);
      vec_t v;
      v.in_f = in_f; v.target = tgt; v.vect = vc; v.exp_f = exp_f; v.e_addr = ea; v.e_pc = ep;
      return v;
   endfunction

   task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", what, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus_if.ID_Stall        = 1'b0;
      bus_if.ID_IsBranch     = 1'b0;
      bus_if.ID_BranchTaken  = 1'b0;
      bus_if.ID_BranchTarget = 32'h0;
      bus_if.ID_CancelBDS    = 1'b0;
      bus_if.EXC_Valid       = 1'b0;
      bus_if.EXC_Vector      = 32'h0;
      bus_if.IMEM_Ready      = 1'b0;
      bus_if.IMEM_RData      = 32'hDEAD_BEEF;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".req"},    {31'h0, bus_if.IMEM_Req}, 32'h0);
      check({tag, ".stall"},  {31'h0, bus_if.IF_Stall}, 32'h1);
      check({tag, ".flush"},  {31'h0, bus_if.IF_Flush}, 32'h0);
      check({tag, ".bds"},    {31'h0, bus_if.IF_IsBDS}, 32'h0);
      check({tag, ".instr"},  bus_if.IF_Instruction, 32'h0);
      check({tag, ".pc"},     bus_if.IF_PC, 32'hBFC0_0000);
      check({tag, ".pcadd4"}, bus_if.PCAdd4, 32'hBFC0_0004);
      check({tag, ".addr"},   bus_if.IMEM_Addr, 32'hBFC0_0000);
   endtask

   // Drive one cycle of stimulus, queue what the stage must show, then compare.
   task automatic apply(input int idx, input vec_t v);
      exp_t e, g;
      bus_if.ID_Stall        = v.in_f[5];
      bus_if.IMEM_Ready      = v.in_f[4];
      bus_if.ID_IsBranch     = v.in_f[3];
      bus_if.ID_BranchTaken  = v.in_f[2];
      bus_if.ID_CancelBDS    = v.in_f[1];
      bus_if.EXC_Valid       = v.in_f[0];
      bus_if.ID_BranchTarget = v.target;
      bus_if.EXC_Vector      = v.vect;
      bus_if.IMEM_RData      = v.in_f[4] ? mem_word(v.e_addr) : 32'hDEAD_BEEF;
      e.req    = v.exp_f[4];
      e.addr   = v.e_addr;
      e.stall  = v.exp_f[3];
      e.flush  = v.exp_f[2];
      e.bds    = v.exp_f[1];
      e.instr  = v.exp_f[0] ? mem_word(v.e_pc) : 32'h0;
      e.pc     = v.e_pc;
      e.pcadd4 = v.e_pc + 32'd4;
      exp_q.push_back(e);
      #1;
      g = exp_q.pop_front();
      check($sformatf("v%0d.req", idx),    {31'h0, bus_if.IMEM_Req}, {31'h0, g.req});
      check($sformatf("v%0d.addr", idx),   bus_if.IMEM_Addr, g.addr);
      check($sformatf("v%0d.stall", idx),  {31'h0, bus_if.IF_Stall}, {31'h0, g.stall});
      check($sformatf("v%0d.flush", idx),  {31'h0, bus_if.IF_Flush}, {31'h0, g.flush});
      check($sformatf("v%0d.bds", idx),    {31'h0, bus_if.IF_IsBDS}, {31'h0, g.bds});
      check($sformatf("v%0d.instr", idx),  bus_if.IF_Instruction, g.instr);
      check($sformatf("v%0d.pc", idx),     bus_if.IF_PC, g.pc);
      check($sformatf("v%0d.pcadd4", idx), bus_if.PCAdd4, g.pcadd4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      RST_N = 1'b0;
      drive_idle();

      // sequential fetch
      vecs.push_back(mk(6'b010000, 32'h0, 32'h0, 5'b10001, 32'hBFC0_0000, 32'hBFC0_0000));
      vecs.push_back(mk(6'b010000, 32'h0, 32'h0, 5'b10001, 32'hBFC0_0004, 32'hBFC0_0004));
      vecs.push_back(mk(6'b010000, 32'h0, 32'h0, 5'b10001, 32'hBFC0_0008, 32'hBFC0_0008));
      vecs.push_back(mk(6'b010000, 32'h0, 32'h0, 5'b10001, 32'hBFC0_000C, 32'hBFC0_000C));
      // taken branch in ID while its delay slot is presented
      vecs.push_back(mk(6'b011100, 32'h8000_1000, 32'h0, 5'b10011, 32'hBFC0_0010, 32'hBFC0_0010));
      vecs.push_back(mk(6'b010000, 32'h0, 32'h0, 5'b10001, 32'h8000_1000, 32'h8000_1000));
      // late ready while ID stalls, then HOLD
      vecs.push_back(mk(6'b100000, 32'h0, 32'h0, 5'b11000, 32'h8000_1004, 32'h8000_1004));
      vecs.push_back(mk(6'b100000, 32'h0, 32'h0, 5'b11000, 32'h8000_1004, 32'h8000_1004));
      vecs.push_back(mk(6'b100000, 32'h0, 32'h0, 5'b11000, 32'h8000_1004, 32'h8000_1004));
      vecs.push_back(mk(6'b110000, 32'h0, 32'h0, 5'b10001, 32'h8000_1004, 32'h8000_1004));
      vecs.push_back(mk(6'b100000, 32'h0, 32'h0, 5'b00001, 32'h8000_1004, 32'h8000_1004));
      vecs.push_back(mk(6'b000000, 32'h0, 32'h0, 5'b00001, 32'h8000_1004, 32'h8000_1004));
      vecs.push_back(mk(6'b010000, 32'h0, 32'h0, 5'b10001, 32'h8000_1008, 32'h8000_1008));
      // branch taken while delay-slot fetch still pending
      vecs.push_back(mk(6'b001100, 32'h8000_2000, 32'h0, 5'b11000, 32'h8000_100C, 32'h8000_100C));
      vecs.push_back(mk(6'b000000, 32'h0, 32'h0, 5'b11000, 32'h8000_100C, 32'h8000_100C));
      vecs.push_back(mk(6'b010000, 32'h0, 32'h0, 5'b10011, 32'h8000_100C, 32'h8000_100C));
      vecs.push_back(mk(6'b010000, 32'h0, 32'h0, 5'b10001, 32'h8000_2000, 32'h8000_2000));
      vecs.push_back(mk(6'b011100, 32'hBFC0_001C, 32'h0, 5'b10011, 32'h8000_2004, 32'h8000_2004));
      vecs.push_back(mk(6'b010000, 32'h0, 32'h0, 5'b10001, 32'hBFC0_001C, 32'hBFC0_001C));
      // cancelled delay slot, same cycle and deferred
      vecs.push_back(mk(6'b011010, 32'h0, 32'h0, 5'b10110, 32'hBFC0_0020, 32'hBFC0_0020));
      vecs.push_back(mk(6'b010000, 32'h0, 32'h0, 5'b10001, 32'hBFC0_0024, 32'hBFC0_0024));
      vecs.push_back(mk(6'b001010, 32'h0, 32'h0, 5'b11000, 32'hBFC0_0028, 32'hBFC0_0028));
      vecs.push_back(mk(6'b010000, 32'h0, 32'h0, 5'b10110, 32'hBFC0_0028, 32'hBFC0_0028));
      vecs.push_back(mk(6'b010000, 32'h0, 32'h0, 5'b10001, 32'hBFC0_002C, 32'hBFC0_002C));
      // exception while waiting, DISCARD drops stale data
      vecs.push_back(mk(6'b000001, 32'h0, 32'h8000_0180, 5'b11100, 32'hBFC0_0030, 32'hBFC0_0030));
      vecs.push_back(mk(6'b000000, 32'h0, 32'h0, 5'b11000, 32'hBFC0_0030, 32'h8000_0180));
      vecs.push_back(mk(6'b010000, 32'h0, 32'h0, 5'b11000, 32'hBFC0_0030, 32'h8000_0180));
      vecs.push_back(mk(6'b010000, 32'h0, 32'h0, 5'b10001, 32'h8000_0180, 32'h8000_0180));
      // exception beats a simultaneous branch
      vecs.push_back(mk(6'b011101, 32'h1234_5678, 32'h8000_0200, 5'b10100, 32'h8000_0184, 32'h8000_0184));
      vecs.push_back(mk(6'b010000, 32'h0, 32'h0, 5'b10001, 32'h8000_0200, 32'h8000_0200));
      // second exception inside DISCARD only moves pc
      vecs.push_back(mk(6'b000001, 32'h0, 32'h8000_0300, 5'b11100, 32'h8000_0204, 32'h8000_0204));
      vecs.push_back(mk(6'b000001, 32'h0, 32'h8000_0400, 5'b11100, 32'h8000_0204, 32'h8000_0300));

      repeat (2) @(negedge CLK);
      bus_if.EXC_Valid  = 1'b1;
      bus_if.EXC_Vector = 32'h8000_0180;
      #1;
      check_reset_outputs("reset");
      bus_if.EXC_Valid  = 1'b0;
      bus_if.EXC_Vector = 32'h0;

      @(negedge CLK);
      RST_N = 1'b1;
      bus_if.IMEM_Ready = 1'b1;
      #1;
      check("idle.req",   {31'h0, bus_if.IMEM_Req}, 32'h0);
      check("idle.stall", {31'h0, bus_if.IF_Stall}, 32'h1);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge CLK);
         apply(i, vecs[i]);
      end

      // still discarding at the stale address, then reset asynchronously mid-cycle
      @(negedge CLK);
      drive_idle();
      #1;
      check("discard.addr",  bus_if.IMEM_Addr, 32'h8000_0204);
      check("discard.pc",    bus_if.IF_PC, 32'h8000_0400);
      check("discard.req",   {31'h0, bus_if.IMEM_Req}, 32'h1);
      check("discard.stall", {31'h0, bus_if.IF_Stall}, 32'h1);
      check("discard.flush", {31'h0, bus_if.IF_Flush}, 32'h0);
      #2;
      RST_N = 1'b0;
      #1;
      check_reset_outputs("midreset");

      @(negedge CLK);
      RST_N = 1'b1;
      bus_if.IMEM_Ready = 1'b1;
      bus_if.IMEM_RData = mem_word(32'hBFC0_0000);
      @(negedge CLK);
      #1;
      check("restart.req",   {31'h0, bus_if.IMEM_Req}, 32'h1);
      check("restart.addr",  bus_if.IMEM_Addr, 32'hBFC0_0000);
      check("restart.stall", {31'h0, bus_if.IF_Stall}, 32'h0);
      check("restart.instr", bus_if.IF_Instruction, mem_word(32'hBFC0_0000));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage. It owns the architectural fetch PC, drives the instruction-memory request/ready handshake, and produces the per-cycle fetch bundle consumed by the IF/ID pipeline register:
- instruction, PC, PC+4
- branch-delay-slot flag
- stall and flush flags

Redirects come from ID (branch/jump, resolved in ID) and from the exception unit.

Parameters:
RESET_VECTOR, 32'hBFC0_0000, PC loaded on reset
IMEM_AW, 32, instruction address width (PC width)

Ports:
CLK  in  1  clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
ID_Stall  in  1  ID stage holding; IF bundle not accepted this cycle
ID_IsBranch  in  1  ID holds branch/jump (next IF instr is its delay slot); valid when !ID_Stall
ID_BranchTaken  in  1  ID branch/jump taken; valid when !ID_Stall
ID_BranchTarget  in  32  taken target
ID_CancelBDS  in  1  branch-likely not taken: delay slot must be flushed; valid when !ID_Stall
EXC_Valid  in  1  exception/ERET redirect, highest priority
EXC_Vector  in  32  redirect PC
IMEM_Req  out  1  fetch request
IMEM_Addr  out  32  fetch address; stable while IMEM_Req && !IMEM_Ready
IMEM_Ready  in  1  request accepted, IMEM_RData valid same cycle
IMEM_RData  in  32  instruction word
IF_Instruction  out  32  instruction to IF/ID
IF_PC  out  32  PC of IF_Instruction
PCAdd4  out  32  IF_PC + 4, modulo 2^32
IF_IsBDS  out  1  IF instruction is a delay slot
IF_Stall  out  1  no valid instruction this cycle
IF_Flush  out  1  IF instruction must become NOP

Behaviour:
- States:
  - IDLE: reset only
  - FETCH: IMEM_Req=1, waiting
  - HOLD: word captured, ID stalled
  - DISCARD: outstanding request is stale
- Reset (async, RST_N=0):
  - pc=RESET_VECTOR; state=IDLE
  - hold_reg=0; bds_flag=0; cancel_flag=0; pend_valid=0; pend_target=0
- Outputs during reset:
  - IMEM_Req=0
  - IF_Stall=1, IF_Flush=0, IF_IsBDS=0
  - IF_Instruction=0
  - IF_PC=RESET_VECTOR
- IDLE -> FETCH on the first clock after release; IMEM_Addr=pc throughout.
- valid = (FETCH && IMEM_Ready) || HOLD. IF_Stall = !valid.
- IF_Instruction (combinational, zero added latency):
  - IMEM_RData in FETCH
  - hold_reg in HOLD
  - 0 when !valid or IF_Flush
- IF_PC=pc; PCAdd4=pc+4.
- Accept = valid && !ID_Stall. Next pc on accept:
  - pend_target if pend_valid
  - else ID_BranchTarget if (ID_BranchTaken && !ID_Stall && !IF_IsBDS-consumed-earlier)
  - else pc+4
  - pend_valid then clears.
- Branch taken while the delay slot is not yet accepted (IF_Stall or ID still stalled is not possible, since the branch is only valid with !ID_Stall): set pend_valid, pend_target. PC stays on the delay slot until it is accepted.
- FETCH transitions:
  - Ready && ID_Stall -> HOLD, capture hold_reg
  - Ready && !ID_Stall -> FETCH at the new pc next cycle
  - !Ready -> stay
- HOLD && !ID_Stall -> FETCH (new pc).
- bds_flag (drives IF_IsBDS):
  - set on ID_IsBranch && !ID_Stall
  - cleared on accept of the flagged instruction
- cancel_flag:
  - set with ID_CancelBDS && !ID_Stall
  - IF_Flush=1 on the cycle the delay slot is valid; cleared on accept
- EXC_Valid (overrides everything):
  - IF_Flush=1 that cycle
  - pc<=EXC_Vector
  - bds_flag, cancel_flag, pend_valid cleared
  - FETCH && !Ready -> DISCARD
  - FETCH && Ready, or HOLD -> FETCH
- DISCARD: IMEM_Req=1 at the stale address, IF_Stall=1. On Ready, data is dropped -> FETCH at pc. A second EXC_Valid in DISCARD only updates pc.
- Simultaneous EXC_Valid and branch inputs: the exception wins; branch inputs are ignored.

Optional Feature:
IF_ADDR_ERR_EN
- Defined:
  - adds output IF_AddrErr (1 bit)
  - when pc[1:0]!=0 in FETCH: no IMEM_Req, valid=1, IF_Instruction=0, IF_AddrErr=1, IF_PC=faulting pc; held until accept or EXC_Valid
  - reset value of IF_AddrErr is 0
- Undefined: IMEM_Addr[1:0] is forced to 0 and there is no IF_AddrErr port.

Test Plan:
1. Reset release, IMEM_Ready tied 1, ID_Stall=0 -> IMEM_Addr sequence BFC00000, BFC00004, BFC00008 on consecutive cycles; PCAdd4 = addr+4; IF_Stall=0 from 2nd cycle.
2. Ready arrives 3 cycles late while ID_Stall=1 for 2 more cycles -> IF_Stall=1 for 3 cycles, then HOLD presents the same word/PC until ID_Stall drops; no duplicate or lost instruction.
3. ID_IsBranch=1, ID_BranchTaken=1, target 0x80001000 at pc 0xBFC00010 -> delay slot 0xBFC00010 presented with IF_IsBDS=1, next IMEM_Addr 0x80001000.
4. Branch taken while delay-slot fetch is pending (Ready delayed 2 cycles) -> delay slot delivered first, then the target fetched; pend_valid clears.
5. ID_CancelBDS with delay slot 0xBFC00020 -> that instruction shows IF_Flush=1, IF_Instruction=0, IF_IsBDS=1; the following fetch is sequential.
6. EXC_Valid with vector 0x80000180 while FETCH is waiting -> IF_Flush=1, DISCARD until Ready, stale data dropped, next IMEM_Addr 0x80000180; RST_N pulsed mid-DISCARD returns all outputs to reset values immediately.
